mult_datapath: RTL and testbench
================================

// Module: mult_datapath
// PURPOSE
//  Datapath for the 8x8 unsigned shift-add multiplier. It consumes the select lines from the multiplier control FSM and builds a
//  16-bit product from four (WIDTH/2)x(WIDTH/2) nibble partial products, summed in an accumulator.
//  It also produces the step counter that feeds the FSM's count input, and registers the final product with a one-cycle valid pulse.
// PARAMETERS
//  WIDTH     8  operand width; must be even; half-operand H = WIDTH/2
//  CNT_W     3  step-counter width; matches the FSM state encoding
//  DONE_CNT  4  counter value that means finished (FSM FINISH encoding)
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous, active-high reset
//  start        in   1        operation request; held high for the whole operation
//  dataa        in   WIDTH    multiplicand
//  datab        in   WIDTH    multiplier
//  sela         in   1        1: use a_hi = a[WIDTH-1:H]; 0: use a_lo = a[H-1:0]
//  selb         in   1        1: use b_hi; 0: use b_lo
//  sel_shifter  in   2        partial-product shift: 10 = <<WIDTH, 01 = <<H, 00 = <<0, 11 = <<0 (illegal, tolerated)
//  done_flag    in   1        FSM finished indication
//  count        out  CNT_W    step counter to the FSM
//  product      out  2*WIDTH  registered result
//  prod_valid   out  1        one-cycle pulse when product updates
//  busy         out  1        high while start=1 and count<DONE_CNT
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): count=0, acc=0, product=0, prod_valid=0. busy is combinational and is therefore 0.
//    Reset has priority over every other event and aborts an operation in flight.
//  - Counter, registered:
//    * start=0 -> count<=0.
//    * start=1 and count<DONE_CNT -> count<=count+1.
//    * start=1 and count==DONE_CNT -> hold at DONE_CNT.
//    * Because the FSM registers n_state=f(count), FSM state equals count on every cycle.
//  - Partial product: pp = (sela ? a_hi : a_lo) * (selb ? b_hi : b_lo). pp is 2H bits, zero-extended to 2*WIDTH, then shifted
//    per sel_shifter. Arithmetic is unsigned, and no bits are lost at 2*WIDTH.
//  - Accumulator, gated only on count and never on the selects (the selects are X in FINISH):
//    * start=1 and count==0 -> acc<=pp_shifted (load, no add).
//    * start=1 and 0<count<DONE_CNT -> acc<=acc+pp_shifted.
//    * Otherwise acc holds.
//    * Step order from the FSM: hi*hi<<8, hi*lo<<4, lo*hi<<4, lo*lo<<0. The sum after 4 steps is exact.
//  - Result:
//    * On the edge where count goes from DONE_CNT-1 to DONE_CNT, the accumulator takes its last add.
//    * On the next edge, with start=1, count==DONE_CNT and done_flag=1, product<=acc and prod_valid<=1, if not already
//      captured for this operation.
//    * A captured bit, cleared when start=0, limits prod_valid to exactly one pulse per operation. Holding start in FINISH
//      keeps product stable and prod_valid low.
//  - Latency: start rises at edge 0. The four accumulate edges are 1 to 4. product and prod_valid are visible after edge 5.
//  - Abort: start=0 before capture -> count<=0. product and prod_valid are not updated, and the previous product is retained.
//  - Back-to-back: start must go low for at least one cycle between operations. The next rise reloads acc at count==0.
//  - Operands must be stable from start rising until prod_valid, unless OPERAND_LATCH_EN is defined.
// CONFIGURATION
//  OPERAND_LATCH_EN defined:
//   - dataa and datab are registered into internal a_q/b_q on the cycle start=1 and count==0.
//   - The cycle that loads the accumulator uses the live inputs.
//   - Later steps use a_q/b_q, so the inputs may change after the first cycle.
//  OPERAND_LATCH_EN undefined: no operand registers; dataa and datab are used directly every step.
// TESTING
//  1. rst=1 for 2 cycles, then start=1 with 0xFF*0xFF -> count steps 0,1,2,3,4; product=0xFE01; prod_valid high for 1 cycle only.
//  2. 0x12*0x34, start held 10 cycles -> product=0x03A8; exactly one prod_valid pulse; product stable while start stays high.
//  3. 0x00*0x5A after a 0xFF*0xFF result -> product=0x0000 (accumulator loaded, not added, at count 0).
//  4. start dropped at count==2 (product previously 0xFE01) -> count=0 next cycle; no prod_valid; product stays 0xFE01.
//  5. rst=1 at count==3 -> next cycle count=0, acc=0, product=0, prod_valid=0; a new 0x0F*0xF0 operation gives 0x0E10.
//  6. OPERAND_LATCH_EN, 0xAB*0xCD with inputs changed to 0x00 at count==1 -> product=0x88EF.

Source files
------------

// File: rtl/mult_datapath.sv
// mult_datapath: datapath for the 8x8 unsigned shift-add multiplier.
// Builds the 2*WIDTH product from four half-width partial products that are
// summed in an accumulator. It also runs the step counter that the control FSM
// follows, and registers the result with a one-cycle valid pulse.
// Optional feature: define OPERAND_LATCH_EN to capture the operands on the first
// step, so dataa/datab may change once the operation is under way.
module mult_datapath #(
    parameter int WIDTH    = 8,
    parameter int CNT_W    = 3,
    parameter int DONE_CNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   dataa,
    input  logic [WIDTH-1:0]   datab,
    input  logic               sela,
    input  logic               selb,
    input  logic [1:0]         sel_shifter,
    input  logic               done_flag,
    output logic [CNT_W-1:0]   count,
    output logic [2*WIDTH-1:0] product,
    output logic               prod_valid,
    output logic               busy
);

    localparam int H = WIDTH / 2;
    localparam logic [CNT_W-1:0] DONE_C = CNT_W'(DONE_CNT);

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [H-1:0]       a_sel;
    logic [H-1:0]       b_sel;
    logic [2*H-1:0]     pp;
    logic [2*WIDTH-1:0] pp_ext;
    logic [2*WIDTH-1:0] pp_shifted;
    logic [2*WIDTH-1:0] acc;
    logic               captured;
    logic               first_step;

    // The first step of an operation is the cycle that loads the accumulator
    assign first_step = start && (count == '0);

`ifdef OPERAND_LATCH_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Capture the operands on the first step so later steps can ignore the inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (first_step) begin
            a_q <= dataa;
            b_q <= datab;
        end
    end

    // The loading step has no captured copy yet, so it uses the live inputs
    always_comb begin
        op_a = a_q;
        op_b = b_q;
        if (first_step) begin
            op_a = dataa;
            op_b = datab;
        end
    end
`else
    // Without operand registers the inputs feed every step directly
    always_comb begin
        op_a = dataa;
        op_b = datab;
    end
`endif

    // Pick the operand halves and form the shifted partial product
    always_comb begin
        a_sel = sela ? op_a[WIDTH-1:H] : op_a[H-1:0];
        b_sel = selb ? op_b[WIDTH-1:H] : op_b[H-1:0];
        pp = {{H{1'b0}}, a_sel} * {{H{1'b0}}, b_sel};
        pp_ext = {{(2*WIDTH-2*H){1'b0}}, pp};
        case (sel_shifter)
            2'b10:   pp_shifted = pp_ext << WIDTH;
            2'b01:   pp_shifted = pp_ext << H;
            default: pp_shifted = pp_ext;
        endcase
    end

    // Step counter: runs while start is high, parks at DONE_C, clears when start drops
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (!start) begin
            count <= '0;
        end else if (count < DONE_C) begin
            count <= count + 1'b1;
        end
    end

    // Accumulator is gated on count only; the selects are undefined once finished
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (first_step) begin
            acc <= pp_shifted;
        end else if (start && (count < DONE_C)) begin
            acc <= acc + pp_shifted;
        end
    end

    // Capture the result once per operation; captured clears when start drops
    always_ff @(posedge clk) begin
        if (rst) begin
            product    <= '0;
            prod_valid <= 1'b0;
            captured   <= 1'b0;
        end else begin
            prod_valid <= 1'b0;
            if (!start) begin
                captured <= 1'b0;
            end else if ((count == DONE_C) && done_flag && !captured) begin
                product    <= acc;
                prod_valid <= 1'b1;
                captured   <= 1'b1;
            end
        end
    end

    assign busy = start && (count < DONE_C);

endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: directed, table-driven bench for mult_datapath.
// The bench plays the part of the control FSM, driving the selects and
// done_flag from its own step index.
module tb_mult_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic        sela;
    logic        selb;
    logic [1:0]  sel_shifter;
    logic        done_flag;
    logic [2:0]  count;
    logic [15:0] product;
    logic        prod_valid;
    logic        busy;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          hold;
        logic [15:0] expProd;
    } vec_t;

    vec_t vecs[9];

    mult_datapath #(.WIDTH(8), .CNT_W(3), .DONE_CNT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dataa       (dataa),
        .datab       (datab),
        .sela        (sela),
        .selb        (selb),
        .sel_shifter (sel_shifter),
        .done_flag   (done_flag),
        .count       (count),
        .product     (product),
        .prod_valid  (prod_valid),
        .busy        (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Compare one observed value against the bench's expectation
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // FSM model: selects for step s (hi*hi<<8, hi*lo<<4, lo*hi<<4, lo*lo<<0, then FINISH)
    task automatic driveStep(input int s);
        done_flag = (s >= 4);
        case (s)
            0:       begin sela = 1'b1; selb = 1'b1; sel_shifter = 2'b10; end
            1:       begin sela = 1'b1; selb = 1'b0; sel_shifter = 2'b01; end
            2:       begin sela = 1'b0; selb = 1'b1; sel_shifter = 2'b01; end
            3:       begin sela = 1'b0; selb = 1'b0; sel_shifter = 2'b00; end
            default: begin sela = 1'b1; selb = 1'b1; sel_shifter = 2'b11; end
        endcase
    endtask

    // Run one full operation holding start for hold cycles, then drop start
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int hold,
                                 input logic [15:0] expProd);
        int pulses;
        int expCnt;
        pulses = 0;
        dataa = a;
        datab = b;
        start = 1'b1;
        driveStep(0);
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk);
            #1;
            driveStep(k);
            expCnt = (k < 4) ? k : 4;
            if (prod_valid) pulses++;
            if (k <= 5) begin
                checkOutput("count", 32'(count), 32'(expCnt));
                checkOutput("busy", 32'(busy), 32'(k < 4));
            end
            if (k == 5) begin
                checkOutput("prod_valid_pulse", 32'(prod_valid), 32'd1);
                checkOutput("product", 32'(product), 32'(expProd));
            end else if (k > 5) begin
                checkOutput("prod_valid_low", 32'(prod_valid), 32'd0);
                checkOutput("product_stable", 32'(product), 32'(expProd));
            end
        end
        checkOutput("pulse_count", 32'(pulses), 32'd1);
        start = 1'b0;
        driveStep(0);
        @(posedge clk);
        #1;
        checkOutput("idle_count", 32'(count), 32'd0);
        checkOutput("idle_product", 32'(product), 32'(expProd));
        checkOutput("idle_valid", 32'(prod_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'hFF, 8'hFF, 6,  16'hFE01};
        vecs[1] = '{8'h12, 8'h34, 10, 16'h03A8};
        vecs[2] = '{8'hFF, 8'hFF, 6,  16'hFE01};
        vecs[3] = '{8'h00, 8'h5A, 6,  16'h0000};
        vecs[4] = '{8'h80, 8'h02, 6,  16'h0100};
        vecs[5] = '{8'h01, 8'h01, 6,  16'h0001};
        vecs[6] = '{8'h7F, 8'hFF, 7,  16'h7E81};
        vecs[7] = '{8'hA5, 8'h5A, 6,  16'h3A02};
        vecs[8] = '{8'hFF, 8'hFF, 6,  16'hFE01};

        rst = 1'b1;
        start = 1'b0;
        dataa = '0;
        datab = '0;
        driveStep(0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_product", 32'(product), 32'd0);
        checkOutput("reset_valid", 32'(prod_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].expProd);
        end

        // Abort at count==2: previous product 0xFE01 must survive
        dataa = 8'h12;
        datab = 8'h34;
        start = 1'b1;
        driveStep(0);
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk);
            #1;
            driveStep(k);
        end
        checkOutput("abort_pre_count", 32'(count), 32'd2);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_count", 32'(count), 32'd0);
            checkOutput("abort_valid", 32'(prod_valid), 32'd0);
            checkOutput("abort_product", 32'(product), 32'hFE01);
        end

        // Reset at count==3 clears everything; a fresh operation then works
        dataa = 8'h55;
        datab = 8'h55;
        start = 1'b1;
        driveStep(0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            driveStep(k);
        end
        checkOutput("rst_pre_count", 32'(count), 32'd3);
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_product", 32'(product), 32'd0);
        checkOutput("midrst_valid", 32'(prod_valid), 32'd0);
        rst = 1'b0;
        applyStimulus(8'h0F, 8'hF0, 6, 16'h0E10);

`ifdef OPERAND_LATCH_EN
        // Operands change after the first step; the latched copy must be used
        dataa = 8'hAB;
        datab = 8'hCD;
        start = 1'b1;
        driveStep(0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            driveStep(k);
            if (k == 1) begin
                dataa = 8'h00;
                datab = 8'h00;
            end
            if (k == 5) begin
                checkOutput("latch_valid", 32'(prod_valid), 32'd1);
                checkOutput("latch_product", 32'(product), 32'h88EF);
            end
        end
        start = 1'b0;
        @(posedge clk);
        #1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
